ili9341_seq: RTL and testbench
==============================

Name: ili9341_seq

Overview:
Command/data sequencer for the ILI9341 SPI byte engine. Sequences every byte the engine sends and drives the panel side-band lines (DC, CS_n, RST_n).
- Runs a fixed power-up init script with timed delays.
- Then serves window-write requests: CASET/PASET/RAMWR followed by a streamed RGB565 pixel burst.
- Sits between the pixel source / top-level control and the byte-serialising SPI engine.

Parameters:
RST_CYCLES, 1000, clk cycles lcd_rst_n held low during hardware reset
RST_WAIT, 600000, clk cycles after lcd_rst_n release and after SWRESET before next command
SLP_WAIT, 12000000, clk cycles after SLPOUT before next command
CNT_W, 24, width of delay counter; must hold the largest wait value

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
start_init  in  1  pulse: begin hardware reset + init script (honoured only in IDLE or UNINIT)
init_done  out  1  level, high once init script completed; cleared by rst or start_init
win_start  in  1  pulse: begin window write (honoured only in IDLE with init_done=1)
x0, x1, y0, y1  in  16 each  window bounds, sampled on accepted win_start
pix_valid  in  1  pixel source has data
pix_data  in  16  RGB565 pixel
pix_last  in  1  qualifies final pixel of burst
pix_ready  out  1  pixel accepted when pix_valid&pix_ready
busy  out  1  high in every state except UNINIT and IDLE
spi_send  out  1  one-cycle request to engine to transmit spi_byte
spi_byte  out  8  byte to transmit
spi_load  in  1  engine idle/ready to accept send
spi_done  in  1  engine one-cycle completion pulse
lcd_dc  out  1  0=command byte, 1=parameter/pixel byte
lcd_cs_n  out  1  panel chip select, active low
lcd_rst_n  out  1  panel hardware reset, active low

Behaviour:
- Reset values: init_done=0, pix_ready=0, busy=0, spi_send=0, spi_byte=0x00, lcd_dc=0, lcd_cs_n=1, lcd_rst_n=1; state UNINIT; delay counter 0.
- rst assertion mid-operation aborts immediately; no further spi_send; the engine is reset by the same rst.
- Byte handshake (all byte-sending states):
  - spi_byte and lcd_dc are set, then spi_send pulses for exactly one cycle in the first cycle spi_load=1.
  - spi_byte and lcd_dc are held stable until spi_done; the next byte is issued no earlier than the cycle after spi_done.
  - spi_done outside a wait-for-done state is ignored.
- States: UNINIT, HW_RST, HW_WAIT, INIT_BYTE, INIT_WAIT, INIT_DELAY, IDLE, WIN_BYTE, WIN_WAIT, PIX_GET, PIX_HI, PIX_LO, FINISH.
- start_init (UNINIT/IDLE): init_done=0; HW_RST drives lcd_rst_n=0 for RST_CYCLES; HW_WAIT lcd_rst_n=1 for RST_WAIT; then script.
- Init script, index 0..8 (C=command dc=0, P=param dc=1, with the delay applied after the byte's done):
  - C 0x01 (delay RST_WAIT)
  - C 0x11 (delay SLP_WAIT)
  - C 0x3A, P 0x55
  - C 0x36, P 0x48
  - C 0x29
  - C 0x2C, C 0x00 (NOP terminator)
- Init CS and completion:
  - lcd_cs_n=0 from the first script byte to the end of the script, including during delays.
  - After the last byte: lcd_cs_n=1, init_done=1, go to IDLE.
- win_start (IDLE, init_done=1): latch bounds; lcd_cs_n=0; send 11 bytes in this order:
  - C 0x2A, P x0[15:8], P x0[7:0], P x1[15:8], P x1[7:0]
  - C 0x2B, P y0[15:8], P y0[7:0], P y1[15:8], P y1[7:0]
  - C 0x2C
  - then go to PIX_GET.
- Window bounds are not range-checked; values are sent verbatim.
- Pixel streaming:
  - PIX_GET: pix_ready=1 for the first pixel and for each subsequent pixel only in PIX_GET. On handshake, latch pix_data and pix_last, and set pix_ready=0 the next cycle.
  - PIX_HI sends P data[15:8]; PIX_LO sends P data[7:0].
  - After PIX_LO done: return to PIX_GET if the latched last=0, else go to FINISH.
  - pix_valid low simply stalls in PIX_GET; CS stays low.
- FINISH: lcd_cs_n=1 for one cycle, then IDLE.
- Command pulses that are not honoured:
  - win_start while busy or before init_done, and start_init while busy, are ignored (not queued).
  - Simultaneous start_init and win_start in IDLE: start_init wins.
- Delay counter counts up to param-1 and exits on terminal count; a zero-length delay is not permitted (parameters must be ≥1).

Test Plan:
- Reset then start_init with RST_CYCLES=4, RST_WAIT=8, SLP_WAIT=16 -> lcd_rst_n low exactly 4 cycles; bytes 01,11,3A,55,36,48,29,2C,00 with dc 0,0,0,1,0,1,0,0,0; ≥8/16 idle cycles after 01/11; init_done=1, cs_n=1.
- Engine model with spi_load delayed 3 cycles and done after 9 -> exactly one spi_send per byte; spi_byte/lcd_dc stable from send to done.
- win_start x0=0x0000, x1=0x00EF, y0=0x0010, y1=0x013F, then 2 pixels 0xF800, 0x07E0 (last on second) -> bytes 2A 00 00 00 EF 2B 00 10 01 3F 2C F8 00 07 E0; dc=0 only on 2A/2B/2C; cs_n returns high.
- pix_valid dropped 20 cycles between pixels -> no spi_send during stall, cs_n stays 0, pix_ready=1 throughout the stall.
- win_start before init_done and during pixel burst -> ignored, no extra bytes; start_init+win_start same cycle in IDLE -> init script runs.
- rst asserted mid-window (after byte 0x2B) -> outputs immediately at reset values, state UNINIT, init_done=0.

Source files
------------

// File: rtl/ili9341_seq_if.sv
// Signal bundle between the ILI9341 sequencer, its control/pixel source, the SPI byte engine and the panel.
interface ili9341_seq_if;
   logic        start_init;
   logic        init_done;
   logic        win_start;
   logic [15:0] x0;
   logic [15:0] x1;
   logic [15:0] y0;
   logic [15:0] y1;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        pix_last;
   logic        pix_ready;
   logic        busy;
   logic        spi_send;
   logic [7:0]  spi_byte;
   logic        spi_load;
   logic        spi_done;
   logic        lcd_dc;
   logic        lcd_cs_n;
   logic        lcd_rst_n;

   modport slave (
      input  start_init, win_start, x0, x1, y0, y1, pix_valid, pix_data, pix_last, spi_load, spi_done,
      output init_done, pix_ready, busy, spi_send, spi_byte, lcd_dc, lcd_cs_n, lcd_rst_n
   );

   modport master (
      output start_init, win_start, x0, x1, y0, y1, pix_valid, pix_data, pix_last, spi_load, spi_done,
      input  init_done, pix_ready, busy, spi_send, spi_byte, lcd_dc, lcd_cs_n, lcd_rst_n
   );
endinterface

// File: rtl/ili9341_seq.sv
// ILI9341 command/data sequencer: power-up init script, then CASET/PASET/RAMWR window writes with RGB565 streaming.
module ili9341_seq #(
   parameter int unsigned RST_CYCLES = 1000,
   parameter int unsigned RST_WAIT   = 600000,
   parameter int unsigned SLP_WAIT   = 12000000,
   parameter int unsigned CNT_W      = 24
) (
   input logic          clk,
   input logic          rst,
   ili9341_seq_if.slave bus
);
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam logic [IDX_W-1:0] INIT_LAST   = IDX_W'(8);
   localparam logic [IDX_W-1:0] WIN_LAST    = IDX_W'(10);
   localparam logic [CNT_W-1:0] RST_CYC_TC  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_WAIT_TC = CNT_W'(RST_WAIT - 1);
   localparam logic [CNT_W-1:0] SLP_WAIT_TC = CNT_W'(SLP_WAIT - 1);

   typedef enum logic [3:0] {
      UNINIT, HW_RST, HW_WAIT, INIT_BYTE, INIT_WAIT, INIT_DELAY, IDLE,
      WIN_BYTE, WIN_WAIT, PIX_GET, PIX_HI, PIX_LO, FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
   logic [15:0]       x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic [BYTE_W-1:0] pix_lo_q, pix_lo_d;
   logic              last_q, last_d, sent_q, sent_d;
   logic              init_done_q, init_done_d, pix_ready_q, pix_ready_d, busy_q, busy_d;
   logic              spi_send_q, spi_send_d, lcd_dc_q, lcd_dc_d;
   logic              lcd_cs_n_q, lcd_cs_n_d, lcd_rst_n_q, lcd_rst_n_d;
   logic [BYTE_W-1:0] spi_byte_q, spi_byte_d;

   // {dc, byte} of each init script entry
   function automatic logic [BYTE_W:0] init_rom(input logic [IDX_W-1:0] i);
      logic [BYTE_W:0] r;
      case (i)
         4'd0:    r = {1'b0, 8'h01};
         4'd1:    r = {1'b0, 8'h11};
         4'd2:    r = {1'b0, 8'h3A};
         4'd3:    r = {1'b1, 8'h55};
         4'd4:    r = {1'b0, 8'h36};
         4'd5:    r = {1'b1, 8'h48};
         4'd6:    r = {1'b0, 8'h29};
         4'd7:    r = {1'b0, 8'h2C};
         default: r = {1'b0, 8'h00};
      endcase
      return r;
   endfunction

   // {dc, byte} of each window-setup entry; bounds go out big-endian
   function automatic logic [BYTE_W:0] win_rom(input logic [IDX_W-1:0] i, input logic [15:0] a0,
                                               input logic [15:0] a1, input logic [15:0] b0,
                                               input logic [15:0] b1);
      logic [BYTE_W:0] r;
      case (i)
         4'd0:    r = {1'b0, 8'h2A};
         4'd1:    r = {1'b1, a0[15:8]};
         4'd2:    r = {1'b1, a0[7:0]};
         4'd3:    r = {1'b1, a1[15:8]};
         4'd4:    r = {1'b1, a1[7:0]};
         4'd5:    r = {1'b0, 8'h2B};
         4'd6:    r = {1'b1, b0[15:8]};
         4'd7:    r = {1'b1, b0[7:0]};
         4'd8:    r = {1'b1, b1[15:8]};
         4'd9:    r = {1'b1, b1[7:0]};
         default: r = {1'b0, 8'h2C};
      endcase
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      y0_d        = y0_q;
      y1_d        = y1_q;
      pix_lo_d    = pix_lo_q;
      last_d      = last_q;
      sent_d      = sent_q;
      init_done_d = init_done_q;
      pix_ready_d = 1'b0;
      spi_send_d  = 1'b0;
      spi_byte_d  = spi_byte_q;
      lcd_dc_d    = lcd_dc_q;
      lcd_cs_n_d  = lcd_cs_n_q;
      lcd_rst_n_d = lcd_rst_n_q;
      idx_nxt     = idx_q + IDX_W'(1);

      case (state_q)
         UNINIT, IDLE: begin
            // init_done is only ever set in IDLE, so win_start is inert in UNINIT
            if (bus.start_init) begin
               init_done_d = 1'b0;
               lcd_rst_n_d = 1'b0;
               cnt_d       = '0;
               state_d     = HW_RST;
            end else if (bus.win_start && init_done_q) begin
               x0_d       = bus.x0;
               x1_d       = bus.x1;
               y0_d       = bus.y0;
               y1_d       = bus.y1;
               idx_d      = '0;
               {lcd_dc_d, spi_byte_d} = win_rom(IDX_W'(0), bus.x0, bus.x1, bus.y0, bus.y1);
               lcd_cs_n_d = 1'b0;
               state_d    = WIN_BYTE;
            end
         end
         HW_RST: begin
            if (cnt_q == RST_CYC_TC) begin
               cnt_d       = '0;
               lcd_rst_n_d = 1'b1;
               state_d     = HW_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HW_WAIT: begin
            if (cnt_q == RST_WAIT_TC) begin
               cnt_d      = '0;
               idx_d      = '0;
               {lcd_dc_d, spi_byte_d} = init_rom(IDX_W'(0));
               lcd_cs_n_d = 1'b0;
               state_d    = INIT_BYTE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         INIT_BYTE, WIN_BYTE: begin
            if (bus.spi_load) begin
               spi_send_d = 1'b1;
               state_d    = (state_q == INIT_BYTE) ? INIT_WAIT : WIN_WAIT;
            end
         end
         INIT_WAIT: begin
            if (bus.spi_done) begin
               if (idx_q < IDX_W'(2)) begin
                  cnt_d   = '0;
                  state_d = INIT_DELAY;
               end else if (idx_q == INIT_LAST) begin
                  lcd_cs_n_d  = 1'b1;
                  init_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  idx_d   = idx_nxt;
                  {lcd_dc_d, spi_byte_d} = init_rom(idx_nxt);
                  state_d = INIT_BYTE;
               end
            end
         end
         INIT_DELAY: begin
            // SWRESET (index 0) and SLPOUT (index 1) are the only delayed entries
            if (cnt_q == ((idx_q == '0) ? RST_WAIT_TC : SLP_WAIT_TC)) begin
               cnt_d   = '0;
               idx_d   = idx_nxt;
               {lcd_dc_d, spi_byte_d} = init_rom(idx_nxt);
               state_d = INIT_BYTE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WIN_WAIT: begin
            if (bus.spi_done) begin
               if (idx_q == WIN_LAST) begin
                  pix_ready_d = 1'b1;
                  state_d     = PIX_GET;
               end else begin
                  idx_d   = idx_nxt;
                  {lcd_dc_d, spi_byte_d} = win_rom(idx_nxt, x0_q, x1_q, y0_q, y1_q);
                  state_d = WIN_BYTE;
               end
            end
         end
         PIX_GET: begin
            if (bus.pix_valid && pix_ready_q) begin
               pix_lo_d   = bus.pix_data[7:0];
               last_d     = bus.pix_last;
               lcd_dc_d   = 1'b1;
               spi_byte_d = bus.pix_data[15:8];
               sent_d     = 1'b0;
               state_d    = PIX_HI;
            end else begin
               pix_ready_d = 1'b1;
            end
         end
         PIX_HI, PIX_LO: begin
            // sent_q splits each pixel byte state into issue and wait-for-done halves
            if (!sent_q) begin
               if (bus.spi_load) begin
                  spi_send_d = 1'b1;
                  sent_d     = 1'b1;
               end
            end else if (bus.spi_done) begin
               sent_d = 1'b0;
               if (state_q == PIX_HI) begin
                  spi_byte_d = pix_lo_q;
                  state_d    = PIX_LO;
               end else if (last_q) begin
                  lcd_cs_n_d = 1'b1;
                  state_d    = FINISH;
               end else begin
                  pix_ready_d = 1'b1;
                  state_d     = PIX_GET;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = UNINIT;
      endcase

      busy_d = (state_d != UNINIT) && (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= UNINIT;
         cnt_q       <= '0;
         idx_q       <= '0;
         x0_q        <= '0;
         x1_q        <= '0;
         y0_q        <= '0;
         y1_q        <= '0;
         pix_lo_q    <= '0;
         last_q      <= 1'b0;
         sent_q      <= 1'b0;
         init_done_q <= 1'b0;
         pix_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         spi_send_q  <= 1'b0;
         spi_byte_q  <= '0;
         lcd_dc_q    <= 1'b0;
         lcd_cs_n_q  <= 1'b1;
         lcd_rst_n_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         y0_q        <= y0_d;
         y1_q        <= y1_d;
         pix_lo_q    <= pix_lo_d;
         last_q      <= last_d;
         sent_q      <= sent_d;
         init_done_q <= init_done_d;
         pix_ready_q <= pix_ready_d;
         busy_q      <= busy_d;
         spi_send_q  <= spi_send_d;
         spi_byte_q  <= spi_byte_d;
         lcd_dc_q    <= lcd_dc_d;
         lcd_cs_n_q  <= lcd_cs_n_d;
         lcd_rst_n_q <= lcd_rst_n_d;
      end
   end

   assign bus.init_done = init_done_q;
   assign bus.pix_ready = pix_ready_q;
   assign bus.busy      = busy_q;
   assign bus.spi_send  = spi_send_q;
   assign bus.spi_byte  = spi_byte_q;
   assign bus.lcd_dc    = lcd_dc_q;
   assign bus.lcd_cs_n  = lcd_cs_n_q;
   assign bus.lcd_rst_n = lcd_rst_n_q;
endmodule

// File: tb/tb_ili9341_seq.sv
// Scoreboard bench for ili9341_seq: expected {dc,byte} queued by stimulus, popped by a monitor on every spi_send.
module tb_ili9341_seq;
   localparam int unsigned RST_CYCLES = 4;
   localparam int unsigned RST_WAIT   = 8;
   localparam int unsigned SLP_WAIT   = 16;
   localparam int unsigned BUDGET     = 5000;

   logic clk;
   logic rst;
   ili9341_seq_if bus();

   ili9341_seq #(
      .RST_CYCLES(RST_CYCLES), .RST_WAIT(RST_WAIT), .SLP_WAIT(SLP_WAIT), .CNT_W(24)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   int         n_sends = 0;
   int         cyc = 0;
   logic [8:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_ge(input string name, input int act, input int lim);
      n_cmp++;
      if (act < lim) begin
         n_err++;
         $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // SPI engine model: load drops on accept, done 9 cycles after send, load back 3 cycles after done
   int         eng_cnt = 0;
   logic [8:0] eng_held;
   logic       eng_stable;
   initial begin
      bus.spi_load = 1'b1;
      bus.spi_done = 1'b0;
      forever begin
         @(negedge clk);
         bus.spi_done = 1'b0;
         if (rst) begin
            bus.spi_load = 1'b1;
            eng_cnt      = 0;
         end else if (eng_cnt == 0) begin
            if (bus.spi_send && bus.spi_load) begin
               bus.spi_load = 1'b0;
               eng_held     = {bus.lcd_dc, bus.spi_byte};
               eng_stable   = 1'b1;
               eng_cnt      = 1;
            end
         end else begin
            if (eng_cnt <= 9) begin
               if ({bus.lcd_dc, bus.spi_byte} !== eng_held) eng_stable = 1'b0;
               if (eng_cnt == 9) begin
                  bus.spi_done = 1'b1;
                  chk("byte_stable_until_done", 32'(eng_stable), 32'd1);
               end
            end
            eng_cnt++;
            if (eng_cnt == 12) begin
               bus.spi_load = 1'b1;
               eng_cnt      = 0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every spi_send, checks reset pulse width and post-command delays
   int         low_cnt = 0;
   int         done_cyc = 0;
   logic [8:0] done_byte = 9'h1FF;
   logic [8:0] last_sent = 9'h1FF;
   logic [8:0] got;
   initial forever begin
      @(posedge clk);
      #1;
      if (rst) begin
         low_cnt   = 0;
         done_byte = 9'h1FF;
         continue;
      end
      if (!bus.lcd_rst_n) low_cnt++;
      else if (low_cnt != 0) begin
         chk("lcd_rst_n_low_cycles", 32'(low_cnt), 32'(RST_CYCLES));
         low_cnt = 0;
      end
      if (bus.spi_done) begin
         done_cyc  = cyc;
         done_byte = last_sent;
      end
      if (bus.spi_send) begin
         n_sends++;
         got = {bus.lcd_dc, bus.spi_byte};
         chk("send_only_when_load", 32'(bus.spi_load), 32'd1);
         chk("cs_low_at_send", 32'(bus.lcd_cs_n), 32'd0);
         if (done_byte == 9'h001) chk_ge("idle_after_swreset", cyc - done_cyc - 1, int'(RST_WAIT));
         if (done_byte == 9'h011) chk_ge("idle_after_slpout", cyc - done_cyc - 1, int'(SLP_WAIT));
         done_byte = 9'h1FF;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_byte: got dc=%0b byte=0x%02h, expected no transfer", got[8], got[7:0]);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if (got !== e) begin
               n_err++;
               $display("FAIL spi_byte_dc: got dc=%0b byte=0x%02h, expected dc=%0b byte=0x%02h",
                        got[8], got[7:0], e[8], e[7:0]);
            end
         end
         last_sent = got;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
      $fatal(1);
   end

   function automatic bit cond(input int kind, input int arg);
      case (kind)
         0:       return bus.init_done == 1'b1;
         1:       return bus.busy == 1'b0;
         2:       return bus.pix_ready == 1'b1;
         3:       return exp_q.size() == arg;
         default: return 1'b1;
      endcase
   endfunction

   task automatic wait_until(input int kind, input int arg, input string name);
      int t = 0;
      while (!cond(kind, arg) && t < int'(BUDGET)) begin
         @(negedge clk);
         t++;
      end
      if (t >= int'(BUDGET)) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: timeout after %0d cycles", name, t);
      end
   endtask

   task automatic push_init_script();
      exp_q.push_back(9'h001); exp_q.push_back(9'h011); exp_q.push_back(9'h03A);
      exp_q.push_back(9'h155); exp_q.push_back(9'h036); exp_q.push_back(9'h148);
      exp_q.push_back(9'h029); exp_q.push_back(9'h02C); exp_q.push_back(9'h000);
   endtask

   task automatic push_window(input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] b0, input logic [15:0] b1);
      exp_q.push_back(9'h02A);
      exp_q.push_back({1'b1, a0[15:8]}); exp_q.push_back({1'b1, a0[7:0]});
      exp_q.push_back({1'b1, a1[15:8]}); exp_q.push_back({1'b1, a1[7:0]});
      exp_q.push_back(9'h02B);
      exp_q.push_back({1'b1, b0[15:8]}); exp_q.push_back({1'b1, b0[7:0]});
      exp_q.push_back({1'b1, b1[15:8]}); exp_q.push_back({1'b1, b1[7:0]});
      exp_q.push_back(9'h02C);
   endtask

   task automatic pulse(input bit do_init, input bit do_win);
      bus.start_init = do_init;
      bus.win_start  = do_win;
      @(negedge clk);
      bus.start_init = 1'b0;
      bus.win_start  = 1'b0;
   endtask

   task automatic set_window(input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] b0, input logic [15:0] b1);
      bus.x0 = a0; bus.x1 = a1; bus.y0 = b0; bus.y1 = b1;
   endtask

   task automatic push_pixel(input logic [15:0] d, input logic l);
      bus.pix_valid = 1'b1;
      bus.pix_data  = d;
      bus.pix_last  = l;
      exp_q.push_back({1'b1, d[15:8]});
      exp_q.push_back({1'b1, d[7:0]});
      wait_until(2, 0, "pixel_accept");
      @(negedge clk);
      bus.pix_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_init_done"}, 32'(bus.init_done), 32'd0);
      chk({tag, "_pix_ready"}, 32'(bus.pix_ready), 32'd0);
      chk({tag, "_busy"},      32'(bus.busy),      32'd0);
      chk({tag, "_spi_send"},  32'(bus.spi_send),  32'd0);
      chk({tag, "_spi_byte"},  32'(bus.spi_byte),  32'h00);
      chk({tag, "_lcd_dc"},    32'(bus.lcd_dc),    32'd0);
      chk({tag, "_lcd_cs_n"},  32'(bus.lcd_cs_n),  32'd1);
      chk({tag, "_lcd_rst_n"}, 32'(bus.lcd_rst_n), 32'd1);
   endtask

   initial begin
      int   sends0;
      logic stall_ok;
      rst           = 1'b1;
      bus.start_init = 1'b0;
      bus.win_start  = 1'b0;
      bus.pix_valid  = 1'b0;
      bus.pix_data   = '0;
      bus.pix_last   = 1'b0;
      set_window(16'h0, 16'h0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // window request before init is ignored
      set_window(16'h0001, 16'h0002, 16'h0003, 16'h0004);
      pulse(1'b0, 1'b1);
      repeat (5) @(negedge clk);
      chk("win_before_init_busy", 32'(bus.busy), 32'd0);
      chk("win_before_init_sends", 32'(n_sends), 32'd0);

      // power-up init script
      push_init_script();
      pulse(1'b1, 1'b0);
      chk("init_busy", 32'(bus.busy), 32'd1);
      wait_until(0, 0, "init_done_wait");
      chk("init_done_level", 32'(bus.init_done), 32'd1);
      chk("init_cs_n_high", 32'(bus.lcd_cs_n), 32'd1);
      chk("init_idle", 32'(bus.busy), 32'd0);
      chk("init_queue_drained", 32'(exp_q.size()), 32'd0);

      // window write with two pixels and a 20-cycle source stall between them
      set_window(16'h0000, 16'h00EF, 16'h0010, 16'h013F);
      push_window(16'h0000, 16'h00EF, 16'h0010, 16'h013F);
      pulse(1'b0, 1'b1);
      push_pixel(16'hF800, 1'b0);
      wait_until(2, 0, "second_pixel_ready");
      sends0   = n_sends;
      stall_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            bus.start_init = 1'b1;
            bus.win_start  = 1'b1;
         end
         if (i == 11) begin
            bus.start_init = 1'b0;
            bus.win_start  = 1'b0;
         end
         if (!(bus.pix_ready === 1'b1 && bus.lcd_cs_n === 1'b0)) stall_ok = 1'b0;
         @(negedge clk);
      end
      chk("stall_ready_and_cs_held", 32'(stall_ok), 32'd1);
      chk("stall_no_sends", 32'(n_sends), 32'(sends0));
      push_pixel(16'h07E0, 1'b1);
      wait_until(1, 0, "window_finish_wait");
      chk("window_cs_n_high", 32'(bus.lcd_cs_n), 32'd1);
      chk("window_init_done_kept", 32'(bus.init_done), 32'd1);
      chk("window_queue_drained", 32'(exp_q.size()), 32'd0);

      // start_init and win_start together in IDLE: init wins
      set_window(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      push_init_script();
      pulse(1'b1, 1'b1);
      @(negedge clk);
      chk("reinit_clears_done", 32'(bus.init_done), 32'd0);
      chk("reinit_busy", 32'(bus.busy), 32'd1);
      wait_until(0, 0, "reinit_done_wait");
      chk("reinit_cs_n_high", 32'(bus.lcd_cs_n), 32'd1);
      chk("reinit_queue_drained", 32'(exp_q.size()), 32'd0);

      // reset mid-window, right after PASET goes out
      set_window(16'h0102, 16'h0304, 16'h0506, 16'h0708);
      push_window(16'h0102, 16'h0304, 16'h0506, 16'h0708);
      pulse(1'b0, 1'b1);
      wait_until(3, 5, "paset_sent_wait");
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      exp_q.delete();
      sends0 = n_sends;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("midrst_no_sends", 32'(n_sends), 32'(sends0));
      chk("midrst_stays_uninit", 32'(bus.busy), 32'd0);
      chk("midrst_init_done", 32'(bus.init_done), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
